sb_tx_ctrl: RTL
===============

SB_TX_CTRL -- requirements
Module: sb_tx_ctrl

Interface
REQ-001 SHALL have parameter TDISCONNECT_TX, 16, minimum sb_clk cycles sbtx is held low in disconnect.
REQ-002 SHALL have parameter TCONNECT_TX, 25, sb_clk cycles sbtx is held high before the first symbol.
REQ-003 SHALL have parameter BIT_CYCLES, 4, sb_clk cycles per sideband bit, legal range 1..255.
REQ-004 SHALL have port sb_clk  input  1  sideband clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port connect_req  input  1  level; LTSSM requests the connected line state.
REQ-007 SHALL have port disconnect_req  input  1  level; LTSSM forces the disconnected line state.
REQ-008 SHALL have port tx_valid  input  1  symbol byte offered.
REQ-009 SHALL have port tx_data  input  8  byte to send; stable while tx_valid=1 and tx_ready=0.
REQ-010 SHALL have port tx_ready  output  1  byte accepted in the cycle tx_valid and tx_ready are both 1.
REQ-011 SHALL have port sbtx  output  1  registered sideband transmit line.
REQ-012 SHALL have port sb_connected  output  1  high in IDLE and TX.
REQ-013 SHALL have port tdisconnect_tx_done  output  1  high in DISC once the low time has reached TDISCONNECT_TX.

Function
REQ-014 SHALL implement FSM states DISC, SETTLE, IDLE and TX.
REQ-015 SHALL hold sbtx=0 in DISC and count sb_clk cycles from entry, saturating at TDISCONNECT_TX.
REQ-016 SHALL assert tdisconnect_tx_done when the DISC count equals TDISCONNECT_TX, and deassert it on leaving DISC.
REQ-017 SHALL move DISC->SETTLE only when connect_req=1 and tdisconnect_tx_done=1; an earlier connect_req waits.
REQ-018 SHALL drive sbtx=1 in SETTLE for exactly TCONNECT_TX cycles, then move to IDLE.
REQ-019 SHALL drive sbtx=1 and tx_ready=1 in IDLE; tx_ready SHALL be 0 in DISC and SETTLE.
REQ-020 SHALL, on acceptance in cycle N, capture tx_data and drive the start bit (sbtx=0) from cycle N+1.
REQ-021 SHALL send a 10-bit symbol: start 0, tx_data[0] to tx_data[7] LSB first, stop 1.
REQ-022 SHALL hold each bit for exactly BIT_CYCLES cycles, so the symbol spans 10*BIT_CYCLES cycles.
REQ-023 SHALL assert tx_ready in the last cycle of the stop bit; acceptance there starts the next start bit with no idle gap.
REQ-024 SHALL return to IDLE after the stop bit when no byte is accepted in its last cycle.
REQ-025 SHALL ignore tx_valid when tx_ready=0, with no capture and no error.
REQ-026 SHALL give disconnect_req priority over every other input: from any state, next state is DISC with sbtx=0, tx_ready=0, count cleared, and any in-flight symbol aborted.
REQ-027 SHALL resolve simultaneous connect_req and disconnect_req in favour of disconnect.
REQ-028 SHALL restart the DISC count from 0 on every entry into DISC.
REQ-029 SHALL size counters to 16 bits and the bit index to 4 bits, with no wrap-around in any legal configuration.

Reset
REQ-030 SHALL, while rst=0, force state DISC, sbtx=0, tx_ready=0, sb_connected=0, tdisconnect_tx_done=0, and all counters and the shift register to 0.
REQ-031 SHALL abort any symbol immediately on rst assertion mid-operation, and begin counting DISC from 0 after release.

Structure
REQ-032 SHALL take the FSM state enum and the constants SB_SYMBOL_BITS=10, SB_START_BIT=0 and SB_STOP_BIT=1 from shared package sb_pkg.
REQ-033 SHALL be one flat module with no sub-module; bit timing, shift register and FSM live in sb_tx_ctrl.

Verification
REQ-034 Reset release, connect_req=1 from cycle 0 -> sbtx=0 for 16 cycles, tdisconnect_tx_done at count 16, then sbtx=1 for 25 cycles, then sb_connected=1 and tx_ready=1.
REQ-035 In IDLE, tx_data=0xA5 accepted in cycle N, BIT_CYCLES=4 -> sbtx from N+1 is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, tx_ready=1 in cycle N+40.
REQ-036 Bytes 0x00 then 0xFF with tx_valid held high -> 80 contiguous cycles of symbols with no idle cycle between stop and start.
REQ-037 disconnect_req pulsed at bit 3 of a symbol -> sbtx=0 next cycle, tx_ready=0, DISC count restarts, and reconnect is not possible before 16 cycles.
REQ-038 connect_req and disconnect_req both 1 in IDLE -> DISC next cycle; connect_req alone 3 cycles after DISC entry -> SETTLE entered only after tdisconnect_tx_done.
REQ-039 rst asserted mid-SETTLE -> all outputs at their reset values asynchronously, and after release the full 16-cycle DISC sequence repeats.

Source files
------------

// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sb_pkg
//  Description : Shared sideband definitions. Holds the transmit FSM state
//                encoding and the fixed framing constants of a sideband
//                symbol (one start bit, eight data bits LSB first, one stop
//                bit).
//  Revision    : 1.0 - initial release
// ============================================================================
package sb_pkg;

   // Transmit line-state machine
   typedef enum logic [1:0] {
      ST_DISC   = 2'd0,   // line held low, disconnect timer running
      ST_SETTLE = 2'd1,   // line held high before the first symbol
      ST_IDLE   = 2'd2,   // connected, line high, ready for a byte
      ST_TX     = 2'd3    // serialising a symbol
   } sb_state_e;

   // Symbol framing
   localparam int   SB_SYMBOL_BITS = 10;
   localparam logic SB_START_BIT   = 1'b0;
   localparam logic SB_STOP_BIT    = 1'b1;

endpackage : sb_pkg
`default_nettype wire

// File: rtl/sb_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sb_tx_ctrl
//  Description : Sideband transmit controller. Sequences the line through
//                disconnect (low), settle (high) and connected states, and
//                serialises accepted bytes as 10-bit symbols
//                (start 0, data LSB first, stop 1), each bit held for
//                BIT_CYCLES clocks. All outputs are registered.
//  Revision    : 1.0 - initial release
//
//  Ports
//     sb_clk              in   sideband clock, rising edge
//     rst                 in   asynchronous reset, active low
//     connect_req         in   level, request the connected line state
//     disconnect_req      in   level, force the disconnected line state
//     tx_valid            in   byte offered
//     tx_data[7:0]        in   byte to send
//     tx_ready            out  byte accepted when tx_valid & tx_ready
//     sbtx                out  sideband transmit line
//     sb_connected        out  high in IDLE and TX
//     tdisconnect_tx_done out  high in DISC once the low time is complete
// ============================================================================
module sb_tx_ctrl
   import sb_pkg::*;
#(
   parameter int TDISCONNECT_TX = 16,
   parameter int TCONNECT_TX    = 25,
   parameter int BIT_CYCLES     = 4
) (
   input  logic       sb_clk,
   input  logic       rst,
   input  logic       connect_req,
   input  logic       disconnect_req,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       sbtx,
   output logic       sb_connected,
   output logic       tdisconnect_tx_done
);

   localparam logic [15:0] TDISC_CNT  = 16'(TDISCONNECT_TX);
   localparam logic [15:0] TCONN_LAST = 16'(TCONNECT_TX - 1);
   localparam logic [15:0] BIT_LAST   = 16'(BIT_CYCLES - 1);
   localparam logic [3:0]  LAST_IDX   = 4'(SB_SYMBOL_BITS - 1);

   sb_state_e                 state_q, state_d;
   logic [15:0]               cnt_q, cnt_d;       // DISC / SETTLE timer
   logic [15:0]               cyc_q, cyc_d;       // clocks within current bit
   logic [3:0]                idx_q, idx_d;       // bit index within symbol
   logic [SB_SYMBOL_BITS-1:0] shreg_q, shreg_d;   // current bit is [0]
   logic                      sbtx_d, ready_d, conn_d, done_d;
   logic                      accept;

   assign accept = tx_valid & tx_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cyc_d   = cyc_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;

      if (disconnect_req) begin
         // Overrides everything, including an in-flight symbol; holding it
         // keeps the disconnect timer at zero.
         state_d = ST_DISC;
         cnt_d   = '0;
         cyc_d   = '0;
         idx_d   = '0;
         shreg_d = '0;
      end else begin
         case (state_q)
            ST_DISC: begin
               if (connect_req && tdisconnect_tx_done) begin
                  state_d = ST_SETTLE;
                  cnt_d   = '0;
               end else if (cnt_q != TDISC_CNT) begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            ST_SETTLE: begin
               if (cnt_q == TCONN_LAST) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  state_d = ST_TX;
                  shreg_d = {SB_STOP_BIT, tx_data, SB_START_BIT};
                  cyc_d   = '0;
                  idx_d   = '0;
               end
            end
            ST_TX: begin
               if (cyc_q != BIT_LAST) begin
                  cyc_d = cyc_q + 16'd1;
               end else if (idx_q != LAST_IDX) begin
                  cyc_d   = '0;
                  idx_d   = idx_q + 4'd1;
                  shreg_d = {SB_STOP_BIT, shreg_q[SB_SYMBOL_BITS-1:1]};
               end else if (accept) begin
                  // Byte taken in the last stop cycle: next start bit
                  // follows with no idle gap.
                  shreg_d = {SB_STOP_BIT, tx_data, SB_START_BIT};
                  cyc_d   = '0;
                  idx_d   = '0;
               end else begin
                  state_d = ST_IDLE;
                  cyc_d   = '0;
                  idx_d   = '0;
               end
            end
            default: begin
               state_d = ST_DISC;
               cnt_d   = '0;
            end
         endcase
      end

      // Outputs are computed from the next state so they register cleanly.
      sbtx_d  = (state_d == ST_TX) ? shreg_d[0]
                                   : ((state_d == ST_SETTLE) || (state_d == ST_IDLE));
      ready_d = (state_d == ST_IDLE) ||
                ((state_d == ST_TX) && (idx_d == LAST_IDX) && (cyc_d == BIT_LAST));
      conn_d  = (state_d == ST_IDLE) || (state_d == ST_TX);
      done_d  = (state_d == ST_DISC) && (cnt_d == TDISC_CNT);
   end

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         state_q             <= ST_DISC;
         cnt_q               <= '0;
         cyc_q               <= '0;
         idx_q               <= '0;
         shreg_q             <= '0;
         sbtx                <= 1'b0;
         tx_ready            <= 1'b0;
         sb_connected        <= 1'b0;
         tdisconnect_tx_done <= 1'b0;
      end else begin
         state_q             <= state_d;
         cnt_q               <= cnt_d;
         cyc_q               <= cyc_d;
         idx_q               <= idx_d;
         shreg_q             <= shreg_d;
         sbtx                <= sbtx_d;
         tx_ready            <= ready_d;
         sb_connected        <= conn_d;
         tdisconnect_tx_done <= done_d;
      end
   end

endmodule : sb_tx_ctrl
`default_nettype wire
